wordcount_cmd_sched: RTL and testbench

WORDCOUNT_CMD_SCHED -- requirements
Module: wordcount_cmd_sched

---
 rtl/wordcount_cmd_sched.sv | 162 ++++++++++++++++
 tb/tb_wordcount_cmd_sched.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wordcount_cmd_sched.sv
// Command scheduler for the word-count accelerator: queues host commands and
// dispatches them one at a time to the search/add or result-copy engine.
module wordcount_cmd_sched #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_op,
  input  logic [31:0] cmd_words,
  input  logic [63:0] cmd_offset,
  input  logic        engine_ready,
  output logic        sa_kick,
  input  logic        sa_busy,
  output logic [31:0] sa_num_of_words,
  output logic [63:0] sa_memory_offset,
  output logic        rc_kick,
  input  logic        rc_busy,
  output logic [31:0] rc_offset,
  output logic [31:0] rc_words,
  output logic [63:0] rc_memory_offset,
  output logic [1:0]  sel,
  output logic        busy,
  output logic        done,
  output logic [15:0] err_cnt,
  output logic [4:0]  pending
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] FULL_CNT = 5'(DEPTH);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_GUARD = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_SA   = 2'd1;
  localparam logic [1:0] SEL_RC   = 2'd2;

  localparam logic [31:0] OP_SA = 32'd1;
  localparam logic [31:0] OP_RC = 32'd2;

  logic [2:0]    state;
  logic [31:0]   fifo_op     [DEPTH];
  logic [31:0]   fifo_words  [DEPTH];
  logic [63:0]   fifo_offset [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;
  logic          push;
  logic          pop;
  logic [31:0]   head_op;
  logic [31:0]   head_words;
  logic [63:0]   head_offset;
  logic [31:0]   cur_op;
  logic          cur_legal;
  logic          sel_busy;
  logic          run_done;

  assign cmd_ready   = (count != FULL_CNT);
  assign push        = cmd_valid && cmd_ready;
  assign pop         = (state == S_IDLE) && (count != 5'd0);
  assign pending     = count;
  assign head_op     = fifo_op[rd_ptr];
  assign head_words  = fifo_words[rd_ptr];
  assign head_offset = fifo_offset[rd_ptr];
  assign cur_legal   = (cur_op == OP_SA) || (cur_op == OP_RC);
  assign rc_offset   = 32'd0;

  // Only the engine that owns the accumulators can end the RUN phase.
  assign sel_busy = (sel == SEL_SA) ? sa_busy : rc_busy;
  assign run_done = (state == S_RUN) && !sel_busy;

  assign busy = (state == S_INIT) || (state != S_IDLE) || (count != 5'd0) ||
                sa_busy || rc_busy;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr]     <= cmd_op;
      fifo_words[wr_ptr]  <= cmd_words;
      fifo_offset[wr_ptr] <= cmd_offset;
    end
  end

  // Simultaneous push and pop leave the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_INIT;
    end else begin
      case (state)
        S_INIT:  if (engine_ready) state <= S_IDLE;
        S_IDLE:  if (count != 5'd0) state <= S_ISSUE;
        S_ISSUE: state <= cur_legal ? S_GUARD : S_IDLE;
        S_GUARD: state <= S_RUN;
        S_RUN:   if (run_done) state <= S_IDLE;
        default: state <= S_INIT;
      endcase
    end
  end

  // Kicks and engine parameters are loaded on the pop edge so they are
  // already registered while the FSM sits in ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_op           <= 32'd0;
      sa_kick          <= 1'b0;
      rc_kick          <= 1'b0;
      sa_num_of_words  <= 32'd0;
      sa_memory_offset <= 64'd0;
      rc_words         <= 32'd0;
      rc_memory_offset <= 64'd0;
      sel              <= SEL_NONE;
      done             <= 1'b0;
      err_cnt          <= 16'd0;
    end else begin
      sa_kick <= 1'b0;
      rc_kick <= 1'b0;
      done    <= 1'b0;
      if (pop) begin
        cur_op <= head_op;
        if (head_op == OP_SA) begin
          sa_kick          <= 1'b1;
          sa_num_of_words  <= head_words;
          sa_memory_offset <= head_offset;
          sel              <= SEL_SA;
        end else if (head_op == OP_RC) begin
          rc_kick          <= 1'b1;
          rc_words         <= head_words;
          rc_memory_offset <= head_offset;
          sel              <= SEL_RC;
        end
      end
      if ((state == S_ISSUE) && !cur_legal && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
      if (run_done) begin
        done <= 1'b1;
        sel  <= SEL_NONE;
      end
    end
  end

endmodule

// File: tb/tb_wordcount_cmd_sched.sv
// Directed and randomized bench for wordcount_cmd_sched, checked against a
// transaction-level queue model of accepted commands.
module tb_wordcount_cmd_sched;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_op;
  logic [31:0] cmd_words;
  logic [63:0] cmd_offset;
  logic        engine_ready;
  logic        sa_kick;
  logic        sa_busy;
  logic [31:0] sa_num_of_words;
  logic [63:0] sa_memory_offset;
  logic        rc_kick;
  logic        rc_busy;
  logic [31:0] rc_offset;
  logic [31:0] rc_words;
  logic [63:0] rc_memory_offset;
  logic [1:0]  sel;
  logic        busy;
  logic        done;
  logic [15:0] err_cnt;
  logic [4:0]  pending;

  typedef struct {
    logic [31:0] op;
    logic [31:0] words;
    logic [63:0] offset;
  } cmd_t;

  cmd_t        model_q[$];
  int          checks = 0;
  int          passes = 0;
  int          fails = 0;
  int          exp_err = 0;
  int          outstanding = 0;
  int          done_seen = 0;
  int          sa_left = 0;
  int          rc_left = 0;
  bit          auto_engine = 1'b0;
  logic [1:0]  active_sel = 2'd0;

  always #5 clk = ~clk;

  wordcount_cmd_sched #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_words        (cmd_words),
    .cmd_offset       (cmd_offset),
    .engine_ready     (engine_ready),
    .sa_kick          (sa_kick),
    .sa_busy          (sa_busy),
    .sa_num_of_words  (sa_num_of_words),
    .sa_memory_offset (sa_memory_offset),
    .rc_kick          (rc_kick),
    .rc_busy          (rc_busy),
    .rc_offset        (rc_offset),
    .rc_words         (rc_words),
    .rc_memory_offset (rc_memory_offset),
    .sel              (sel),
    .busy             (busy),
    .done             (done),
    .err_cnt          (err_cnt),
    .pending          (pending)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] op);
    return (op == 32'd1) || (op == 32'd2);
  endfunction

  // Per-cycle transaction checks: every kick must match the oldest legal
  // queued command, illegal ones ahead of it are charged to err_cnt.
  task automatic monitor();
    cmd_t       c;
    logic [1:0] exp_sel;
    checkOutput("cmd_ready_vs_pending", 64'(cmd_ready), 64'(pending != 5'(DEPTH)));
    checkOutput("single_kick", 64'(sa_kick && rc_kick), 64'd0);
    if (done) begin
      checkOutput("done_has_cmd", 64'(outstanding > 0), 64'd1);
      if (outstanding > 0) outstanding--;
      done_seen++;
      exp_sel = 2'd0;
    end else if (sa_kick || rc_kick) begin
      checkOutput("kick_no_overlap", 64'(outstanding), 64'd0);
      while (model_q.size() > 0 && !is_legal(model_q[0].op)) begin
        exp_err++;
        void'(model_q.pop_front());
      end
      checkOutput("kick_has_cmd", 64'(model_q.size() > 0), 64'd1);
      if (model_q.size() > 0) begin
        c = model_q.pop_front();
        checkOutput("kick_type", 64'({sa_kick, rc_kick}),
                    (c.op == 32'd1) ? 64'd2 : 64'd1);
        if (c.op == 32'd1) begin
          checkOutput("sa_words", 64'(sa_num_of_words), 64'(c.words));
          checkOutput("sa_offset", sa_memory_offset, c.offset);
          active_sel = 2'd1;
        end else begin
          checkOutput("rc_words", 64'(rc_words), 64'(c.words));
          checkOutput("rc_mem_offset", rc_memory_offset, c.offset);
          checkOutput("rc_offset", 64'(rc_offset), 64'd0);
          active_sel = 2'd2;
        end
      end
      outstanding++;
      exp_sel = active_sel;
    end else begin
      exp_sel = (outstanding > 0) ? active_sel : 2'd0;
    end
    checkOutput("sel", 64'(sel), 64'(exp_sel));
    if (auto_engine) begin
      if (sa_kick) sa_left = $urandom_range(0, 6);
      else if (sa_left > 0) sa_left--;
      if (rc_kick) rc_left = $urandom_range(0, 6);
      else if (rc_left > 0) rc_left--;
      sa_busy = (sa_left > 0);
      rc_busy = (rc_left > 0);
    end
  endtask

  task automatic applyStimulus();
    bit   acc;
    cmd_t c;
    acc      = cmd_valid && cmd_ready && !reset;
    c.op     = cmd_op;
    c.words  = cmd_words;
    c.offset = cmd_offset;
    @(posedge clk);
    #1;
    if (reset) begin
      model_q.delete();
      exp_err     = 0;
      outstanding = 0;
      sa_left     = 0;
      rc_left     = 0;
    end else begin
      if (acc) model_q.push_back(c);
      monitor();
    end
  endtask

  task automatic setCmd(input logic [31:0] op, input logic [31:0] words,
                        input logic [63:0] offset);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_words  = words;
    cmd_offset = offset;
  endtask

  initial begin
    int          d0;
    bit          took;
    logic [31:0] ops [10] = '{32'd1, 32'd2, 32'd1, 32'd2, 32'd1, 32'd2,
                              32'd0, 32'd3, 32'd7, 32'hFFFF_FFFF};
    reset = 1'b1; engine_ready = 1'b0; cmd_valid = 1'b0;
    cmd_op = '0; cmd_words = '0; cmd_offset = '0;
    sa_busy = 1'b0; rc_busy = 1'b0;
    applyStimulus();
    applyStimulus();
    $display("[TB] reset state");
    checkOutput("rst_pending", 64'(pending), 64'd0);
    checkOutput("rst_sel", 64'(sel), 64'd0);
    checkOutput("rst_sa_kick", 64'(sa_kick), 64'd0);
    checkOutput("rst_rc_kick", 64'(rc_kick), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_err_cnt", 64'(err_cnt), 64'd0);
    checkOutput("rst_sa_words", 64'(sa_num_of_words), 64'd0);
    checkOutput("rst_sa_offset", sa_memory_offset, 64'd0);
    checkOutput("rst_rc_words", 64'(rc_words), 64'd0);
    checkOutput("rst_rc_mem_offset", rc_memory_offset, 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd1);
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    reset = 1'b0;

    $display("[TB] push while engine not ready");
    setCmd(32'd1, 32'd16, 64'h1000);
    applyStimulus();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("init_no_kick", 64'(sa_kick), 64'd0);
    end
    checkOutput("init_pending", 64'(pending), 64'd1);
    checkOutput("init_busy", 64'(busy), 64'd1);
    engine_ready = 1'b1;
    applyStimulus();
    checkOutput("ready_first_cycle_no_kick", 64'(sa_kick), 64'd0);
    for (int i = 0; i < 4 && !sa_kick; i++) applyStimulus();
    checkOutput("first_sa_kick", 64'(sa_kick), 64'd1);
    checkOutput("first_sa_words", 64'(sa_num_of_words), 64'd16);
    checkOutput("first_sa_offset", sa_memory_offset, 64'h1000);
    checkOutput("first_sel", 64'(sel), 64'd1);

    $display("[TB] long engine busy");
    sa_busy = 1'b1;
    applyStimulus();
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput("busy_no_done", 64'(done), 64'd0);
    end
    sa_busy = 1'b0;
    applyStimulus();
    checkOutput("busy_done_pulse", 64'(done), 64'd1);
    checkOutput("busy_sel_release", 64'(sel), 64'd0);
    applyStimulus();
    checkOutput("busy_done_single", 64'(done), 64'd0);
    checkOutput("busy_idle", 64'(busy), 64'd0);

    $display("[TB] illegal op then result copy");
    setCmd(32'd7, 32'd3, 64'h40);
    applyStimulus();
    setCmd(32'd2, 32'd5, 64'h20);
    applyStimulus();
    cmd_valid = 1'b0;
    for (int i = 0; i < 12 && !rc_kick; i++) applyStimulus();
    checkOutput("illegal_rc_kick", 64'(rc_kick), 64'd1);
    checkOutput("illegal_rc_words", 64'(rc_words), 64'd5);
    checkOutput("illegal_rc_mem_offset", rc_memory_offset, 64'h20);
    checkOutput("illegal_rc_offset", 64'(rc_offset), 64'd0);
    checkOutput("illegal_sel", 64'(sel), 64'd2);
    checkOutput("illegal_err_cnt", 64'(err_cnt), 64'd1);
    rc_busy = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus();
    rc_busy = 1'b0;
    for (int i = 0; i < 8 && !done; i++) applyStimulus();
    checkOutput("illegal_rc_done", 64'(done), 64'd1);

    $display("[TB] fifo full while running");
    setCmd(32'd1, 32'd100, 64'h500);
    applyStimulus();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6 && !sa_kick; i++) applyStimulus();
    checkOutput("full_kick", 64'(sa_kick), 64'd1);
    sa_busy = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus();
    for (int k = 0; k < 4; k++) begin
      setCmd((k % 2 == 0) ? 32'd2 : 32'd1, 32'(k + 1), 64'(k * 256 + 64'h10000));
      checkOutput("full_ready_slot", 64'(cmd_ready), 64'd1);
      applyStimulus();
    end
    checkOutput("full_pending4", 64'(pending), 64'd4);
    checkOutput("full_not_ready", 64'(cmd_ready), 64'd0);
    setCmd(32'd2, 32'd99, 64'hABCD_0000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("full_held_pending", 64'(pending), 64'd4);
    end
    d0 = done_seen;
    auto_engine = 1'b1;
    for (int i = 0; i < 10 && !cmd_ready; i++) applyStimulus();
    checkOutput("full_slot_freed", 64'(cmd_ready), 64'd1);
    applyStimulus();
    cmd_valid = 1'b0;
    checkOutput("full_fifth_accepted", 64'(pending), 64'd4);
    for (int i = 0; i < 200 && busy; i++) applyStimulus();
    checkOutput("full_drained", 64'(busy), 64'd0);
    checkOutput("full_done_count", 64'(done_seen - d0), 64'd6);
    checkOutput("full_model_empty", 64'(model_q.size()), 64'd0);

    $display("[TB] reset during run");
    auto_engine = 1'b0;
    sa_busy = 1'b0; rc_busy = 1'b0;
    setCmd(32'd1, 32'd8, 64'h80);
    applyStimulus();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6 && !sa_kick; i++) applyStimulus();
    sa_busy = 1'b1;
    applyStimulus();
    applyStimulus();
    setCmd(32'd2, 32'd4, 64'h90);
    applyStimulus();
    setCmd(32'd1, 32'd6, 64'hA0);
    applyStimulus();
    cmd_valid = 1'b0;
    checkOutput("rr_pending2", 64'(pending), 64'd2);
    reset = 1'b1;
    applyStimulus();
    checkOutput("rr_pending", 64'(pending), 64'd0);
    checkOutput("rr_sel", 64'(sel), 64'd0);
    checkOutput("rr_sa_kick", 64'(sa_kick), 64'd0);
    checkOutput("rr_rc_kick", 64'(rc_kick), 64'd0);
    checkOutput("rr_done", 64'(done), 64'd0);
    checkOutput("rr_busy_init", 64'(busy), 64'd1);
    reset = 1'b0;
    sa_busy = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus();
    checkOutput("rr_after_pending", 64'(pending), 64'd0);
    checkOutput("rr_after_busy", 64'(busy), 64'd0);

    $display("[TB] randomized traffic");
    auto_engine = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!cmd_valid && $urandom_range(0, 1) == 1)
        setCmd(ops[$urandom_range(0, 9)], $urandom, {$urandom, $urandom});
      took = cmd_valid && cmd_ready;
      applyStimulus();
      if (took) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 300 && busy; i++) applyStimulus();
    checkOutput("rand_drained", 64'(busy), 64'd0);
    d0 = 0;
    while (model_q.size() > 0) begin
      if (is_legal(model_q[0].op)) d0++;
      else exp_err++;
      void'(model_q.pop_front());
    end
    checkOutput("rand_unissued_legal", 64'(d0), 64'd0);
    checkOutput("rand_err_cnt", 64'(err_cnt), 64'(exp_err));
    checkOutput("rand_outstanding", 64'(outstanding), 64'd0);
    checkOutput("rand_pending", 64'(pending), 64'd0);
    checkOutput("rand_sel", 64'(sel), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
